pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the RISC datapath. It is the consuming end of the next-address path: it accepts the MUX C selection (BS-derived sel with BrA/RAA targets), owns PC, and drives PCinc back to MUX C. It also runs a request/ready handshake with instruction memory and a valid/ready handshake into the instruction register / decode stage. On a redirect it squashes in-flight fetches.

---
 rtl/pc_fetch_unit_pkg.sv | 25 ++
 rtl/pc_fetch_unit_if.sv | 34 +++
 rtl/pc_fetch_unit.sv | 107 ++++++++++
 tb/tb_pc_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / instruction-fetch slice: FSM encodings,
// MUX C select codes and default bus widths.
// Pure declarations; no timing or flow-control of its own.
package pc_fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // MUX C select codes; 2'b11 also selects BrA.
   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_BRA  = 2'b01;
   localparam logic [1:0] SEL_RAA  = 2'b10;

   localparam int DEF_AW = 8;
   localparam int DEF_DW = 16;

   // A redirect needs both the valid strobe and a non-null select.
   function automatic logic is_redirect(input logic vld, input logic [1:0] sel);
      return vld && (sel != SEL_NONE);
   endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle of next-address, instruction-memory and decode handshake signals.
// No latency of its own; master = fetch unit, slave = its environment.
// Backpressure: imem_ready stalls fetch, ir_ready stalls the IR hand-off.
interface pc_fetch_unit_if
   import pc_fetch_unit_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
);
   logic          redir_valid;
   logic [1:0]    redir_sel;
   logic [AW-1:0] BrA;
   logic [AW-1:0] RAA;
   logic [AW-1:0] PC;
   logic [AW-1:0] PCinc;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ready;
   logic [DW-1:0] imem_data;
   logic          ir_valid;
   logic [DW-1:0] ir;
   logic [AW-1:0] ir_pc;
   logic          ir_ready;

   modport master (
      input  redir_valid, redir_sel, BrA, RAA, imem_ready, imem_data, ir_ready,
      output PC, PCinc, imem_req, imem_addr, ir_valid, ir, ir_pc
   );

   modport slave (
      output redir_valid, redir_sel, BrA, RAA, imem_ready, imem_data, ir_ready,
      input  PC, PCinc, imem_req, imem_addr, ir_valid, ir, ir_pc
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register + fetch sequencer: fetches at PC, hands the word to decode, redirects on MUX C.
// Latency: imem response -> ir_valid next cycle; at best 1 instruction per 2 cycles.
// Backpressure: FETCH waits on imem_ready (no timeout), HOLD waits on ir_ready; redirect overrides both.
// Ports: clk, rst (async, active-high); bus = pc_fetch_unit_if.master carrying
//   redir_valid/redir_sel/BrA/RAA in, PC/PCinc out, imem_req/imem_addr out with
//   imem_ready/imem_data in, ir_valid/ir/ir_pc out with ir_ready in.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int            AW           = DEF_AW,
   parameter int            DW           = DEF_DW,
   parameter logic [AW-1:0] RESET_PC     = '0,
   parameter int            FLUSH_CYCLES = 2
)
(
   input  logic            clk,
   input  logic            rst,
   pc_fetch_unit_if.master bus
);

   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

   state_t        state, state_nx;
   logic [AW-1:0] pc, pc_nx, pc_inc, target;
   logic [DW-1:0] ir_q, ir_nx;
   logic [AW-1:0] ir_pc_q, ir_pc_nx;
   logic          ir_vld_q, ir_vld_nx;
   logic [3:0]    cnt, cnt_nx;
   logic          redir;

   assign pc_inc = pc + AW'(1);

   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      ir_nx     = ir_q;
      ir_pc_nx  = ir_pc_q;
      ir_vld_nx = ir_vld_q;
      cnt_nx    = cnt;
      redir     = is_redirect(bus.redir_valid, bus.redir_sel);
      target    = (bus.redir_sel == SEL_RAA) ? bus.RAA : bus.BrA;

      if (redir) begin
         // Overrides everything: an imem response this cycle is dropped, and
         // a coincident decode hand-off has already happened on the wire.
         state_nx  = FLUSH;
         pc_nx     = target;
         ir_vld_nx = 1'b0;
         cnt_nx    = '0;
      end else begin
         case (state)
            FETCH: begin
               if (bus.imem_ready) begin
                  ir_nx     = bus.imem_data;
                  ir_pc_nx  = pc;
                  ir_vld_nx = 1'b1;
                  pc_nx     = pc_inc;
                  state_nx  = HOLD;
               end
            end
            HOLD: begin
               if (bus.ir_ready) begin
                  ir_vld_nx = 1'b0;
                  state_nx  = FETCH;
               end
            end
            FLUSH: begin
               if (cnt == FLUSH_LAST) begin
                  state_nx = FETCH;
               end else begin
                  cnt_nx = cnt + 4'd1;
               end
            end
            default: state_nx = FLUSH;
         endcase
      end
   end

   // Counter resets to its terminal value so reset release costs exactly one
   // bubble, while a redirect clears it and costs FLUSH_CYCLES bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FLUSH;
         pc       <= RESET_PC;
         ir_q     <= '0;
         ir_pc_q  <= '0;
         ir_vld_q <= 1'b0;
         cnt      <= FLUSH_LAST;
      end else begin
         state    <= state_nx;
         pc       <= pc_nx;
         ir_q     <= ir_nx;
         ir_pc_q  <= ir_pc_nx;
         ir_vld_q <= ir_vld_nx;
         cnt      <= cnt_nx;
      end
   end

   assign bus.PC        = pc;
   assign bus.PCinc     = pc_inc;
   assign bus.imem_req  = (state == FETCH);
   assign bus.imem_addr = pc;
   assign bus.ir_valid  = ir_vld_q;
   assign bus.ir        = ir_q;
   assign bus.ir_pc     = ir_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: cycle table plus IR scoreboard.
// Main instance at RESET_PC=0, second instance at RESET_PC=8'hFE for wrap.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_pc_fetch_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pc_fetch_unit_if #(.AW(8), .DW(16)) bm ();
   pc_fetch_unit_if #(.AW(8), .DW(16)) bw ();

   pc_fetch_unit #(.AW(8), .DW(16), .RESET_PC(8'h00), .FLUSH_CYCLES(2)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bm)
   );

   pc_fetch_unit #(.AW(8), .DW(16), .RESET_PC(8'hFE), .FLUSH_CYCLES(2)) u_wrap (
      .clk (clk),
      .rst (rst),
      .bus (bw)
   );

   typedef struct packed {
      logic       rv;
      logic [1:0] rs;
      logic [7:0] bra;
      logic [7:0] raa;
      logic       rdy;
      logic       irdy;
      logic       req;
      logic [7:0] pc;
      logic       iv;
      logic [7:0] irpc;
   } vec_t;

   typedef struct packed {
      logic [7:0]  pc;
      logic [15:0] dat;
   } exp_t;

   vec_t vq[$];
   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [15:0] mem(input logic [7:0] a);
      return {a ^ 8'h5A, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic rv, input logic [1:0] rs, input logic [7:0] bra,
                      input logic [7:0] raa, input logic rdy, input logic irdy,
                      input logic req, input logic [7:0] pc, input logic iv,
                      input logic [7:0] irpc);
      vq.push_back('{rv, rs, bra, raa, rdy, irdy, req, pc, iv, irpc});
   endtask

   // Scoreboard consumer: every decode hand-off must match the oldest accepted fetch.
   always @(negedge clk) begin
      if (!rst && bm.ir_valid && bm.ir_ready) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected_handoff", {24'd0, bm.ir_pc}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_ir_pc", {24'd0, bm.ir_pc}, {24'd0, e.pc});
            chk("sb_ir", {16'd0, bm.ir}, {16'd0, e.dat});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] we;
      bm.redir_valid = 1'b0; bm.redir_sel = 2'b00; bm.BrA = '0; bm.RAA = '0;
      bm.imem_ready  = 1'b0; bm.imem_data = '0;    bm.ir_ready = 1'b0;
      bw.redir_valid = 1'b0; bw.redir_sel = 2'b00; bw.BrA = '0; bw.RAA = '0;
      bw.imem_ready  = 1'b1; bw.imem_data = 16'h1234; bw.ir_ready = 1'b1;

      // rv rs bra raa rdy irdy | req pc iv irpc
      add(0,2'd0,8'h00,8'h00,1,1, 0,8'h00,0,8'h00);
      add(0,2'd0,8'h00,8'h00,1,1, 1,8'h00,0,8'h00);
      add(0,2'd0,8'h00,8'h00,1,1, 0,8'h01,1,8'h00);
      add(0,2'd0,8'h00,8'h00,1,1, 1,8'h01,0,8'h00);
      add(0,2'd0,8'h00,8'h00,1,1, 0,8'h02,1,8'h01);
      add(0,2'd0,8'h00,8'h00,1,1, 1,8'h02,0,8'h01);
      add(0,2'd0,8'h00,8'h00,1,1, 0,8'h03,1,8'h02);
      add(0,2'd0,8'h00,8'h00,1,1, 1,8'h03,0,8'h02);
      for (int k = 0; k < 5; k++)
         add(0,2'd0,8'h00,8'h00,1,0, 0,8'h04,1,8'h03);   // decode stalls in HOLD
      add(0,2'd0,8'h00,8'h00,1,1, 0,8'h04,1,8'h03);
      add(0,2'd0,8'h00,8'h00,0,1, 1,8'h04,0,8'h03);
      add(0,2'd0,8'h00,8'h00,0,1, 1,8'h04,0,8'h03);
      add(1,2'd1,8'h40,8'h00,1,1, 1,8'h04,0,8'h03);      // redirect vs imem_ready
      add(0,2'd0,8'h00,8'h00,1,1, 0,8'h40,0,8'h03);
      add(0,2'd0,8'h00,8'h00,1,1, 0,8'h40,0,8'h03);
      add(0,2'd0,8'h00,8'h00,0,1, 1,8'h40,0,8'h03);
      add(1,2'd2,8'h00,8'h20,0,1, 1,8'h40,0,8'h03);      // RAA redirect
      add(0,2'd0,8'h00,8'h00,0,1, 0,8'h20,0,8'h03);
      add(1,2'd1,8'h30,8'h00,0,1, 0,8'h20,0,8'h03);      // re-redirect in FLUSH
      add(0,2'd0,8'h00,8'h00,0,1, 0,8'h30,0,8'h03);
      add(1,2'd0,8'h55,8'h66,1,0, 0,8'h30,0,8'h03);      // sel 00 ignored
      add(1,2'd0,8'h55,8'h66,1,0, 1,8'h30,0,8'h03);
      add(1,2'd0,8'h55,8'h66,1,0, 0,8'h31,1,8'h30);
      add(1,2'd3,8'h80,8'h00,0,1, 0,8'h31,1,8'h30);      // redirect vs ir_ready
      add(0,2'd0,8'h00,8'h00,1,1, 0,8'h80,0,8'h30);
      add(0,2'd0,8'h00,8'h00,1,1, 0,8'h80,0,8'h30);
      add(0,2'd0,8'h00,8'h00,1,1, 1,8'h80,0,8'h30);
      add(0,2'd0,8'h00,8'h00,0,1, 0,8'h81,1,8'h80);
      add(0,2'd0,8'h00,8'h00,0,1, 1,8'h81,0,8'h80);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pc",       {24'd0, bm.PC}, 32'h00);
      chk("rst_req",      {31'd0, bm.imem_req}, 32'd0);
      chk("rst_ir_valid", {31'd0, bm.ir_valid}, 32'd0);
      chk("rst_ir",       {16'd0, bm.ir}, 32'd0);
      chk("rst_ir_pc",    {24'd0, bm.ir_pc}, 32'd0);
      chk("rst_wrap_pc",  {24'd0, bw.PC}, 32'hFE);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         vec_t v;
         v = vq[i];
         bm.redir_valid = v.rv;
         bm.redir_sel   = v.rs;
         bm.BrA         = v.bra;
         bm.RAA         = v.raa;
         bm.imem_ready  = v.rdy;
         bm.ir_ready    = v.irdy;
         bm.imem_data   = (v.rv && v.rs != 2'd0) ? 16'hBEEF : mem(v.pc);
         if (v.req && v.rdy && !(v.rv && v.rs != 2'd0))
            sbq.push_back('{v.pc, mem(v.pc)});
         @(negedge clk);
         chk($sformatf("row%0d_req", i),   {31'd0, bm.imem_req}, {31'd0, v.req});
         chk($sformatf("row%0d_pc", i),    {24'd0, bm.PC}, {24'd0, v.pc});
         chk($sformatf("row%0d_addr", i),  {24'd0, bm.imem_addr}, {24'd0, v.pc});
         chk($sformatf("row%0d_pcinc", i), {24'd0, bm.PCinc}, {24'd0, v.pc + 8'd1});
         chk($sformatf("row%0d_iv", i),    {31'd0, bm.ir_valid}, {31'd0, v.iv});
         chk($sformatf("row%0d_irpc", i),  {24'd0, bm.ir_pc}, {24'd0, v.irpc});
         if (i >= 2)
            chk($sformatf("row%0d_ir", i), {16'd0, bm.ir}, {16'd0, mem(v.irpc)});
         if (i < 8) begin
            we = 8'hFE + 8'(i / 2);
            chk($sformatf("wrap%0d_pc", i),    {24'd0, bw.PC}, {24'd0, we});
            chk($sformatf("wrap%0d_pcinc", i), {24'd0, bw.PCinc}, {24'd0, we + 8'd1});
            chk($sformatf("wrap%0d_iv", i),    {31'd0, bw.ir_valid},
                {31'd0, (i >= 2 && i % 2 == 0)});
            if (i >= 2 && i % 2 == 0)
               chk($sformatf("wrap%0d_irpc", i), {24'd0, bw.ir_pc}, {24'd0, we - 8'd1});
         end
         @(posedge clk); #1;
      end

      // Asynchronous reset mid-FETCH with no memory response pending yet.
      bm.redir_valid = 1'b0; bm.redir_sel = 2'b00; bm.imem_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_pc",       {24'd0, bm.PC}, 32'h00);
      chk("arst_ir_valid", {31'd0, bm.ir_valid}, 32'd0);
      chk("arst_req",      {31'd0, bm.imem_req}, 32'd0);
      chk("arst_ir_pc",    {24'd0, bm.ir_pc}, 32'd0);
      bm.imem_ready = 1'b1;            // late response from the squashed fetch
      bm.imem_data  = 16'hDEAD;
      @(posedge clk); #1;
      rst = 1'b0;
      bm.ir_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_bubble_req", {31'd0, bm.imem_req}, 32'd0);
      chk("post_rst_bubble_iv",  {31'd0, bm.ir_valid}, 32'd0);
      @(posedge clk); #1;
      bm.imem_data = mem(8'h00);
      sbq.push_back('{8'h00, mem(8'h00)});
      @(negedge clk);
      chk("post_rst_req",  {31'd0, bm.imem_req}, 32'd1);
      chk("post_rst_addr", {24'd0, bm.imem_addr}, 32'h00);
      @(posedge clk); #1;
      bm.imem_ready = 1'b0;
      @(negedge clk);
      chk("post_rst_iv", {31'd0, bm.ir_valid}, 32'd1);
      @(posedge clk); #1;

      chk("sb_drained", sbq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
